// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file loader: geometry and loader state encoding.
package regfile_pkg;

   localparam int REG_AW   = 5;
   localparam int REG_DW   = 32;
   localparam int NUM_REGS = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } loader_state_t;

endpackage

// File: rtl/regfile_checksum.sv
// Wrapping DW-bit accumulator with synchronous clear; used for the write-side and readback sums.
module regfile_checksum
   import regfile_pkg::*;
#(
   parameter int DW = REG_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] data,
   output logic [DW-1:0] sum
);

   logic [DW-1:0] sum_r;

   // Accumulator: clear wins over add, sum wraps modulo 2^DW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r <= {DW{1'b0}};
      end else if (clr) begin
         sum_r <= {DW{1'b0}};
      end else if (en) begin
         sum_r <= sum_r + data;
      end else begin
         sum_r <= sum_r;
      end
   end

   assign sum = sum_r;

endmodule

// File: rtl/regfile_loader.sv
// Bulk-loads registers 1..NUM_REGS-1 from a valid/ready stream into the regfile write port.
// Optional readback verify through read port 1 is enabled by defining REGFILE_LOADER_VERIFY_EN.
module regfile_loader
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = regfile_pkg::NUM_REGS,
   parameter int DW       = REG_DW,
   parameter int AW       = REG_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          we3,
   output logic [AW-1:0] wa3,
   output logic [DW-1:0] wd3,
   output logic [AW-1:0] ra1,
   input  logic [DW-1:0] rd1,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] checksum
);

   localparam logic [AW-1:0] ONE_PTR  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] LAST_PTR = AW'(NUM_REGS - 1);

   loader_state_t state_r, state_s;
   logic [AW-1:0] ptr_r, ptr_s;
   logic          clr_s;
   logic          accept_s;
   logic [DW-1:0] wsum_s;
`ifdef REGFILE_LOADER_VERIFY_EN
   logic          rb_en_s;
   logic          verify_last_s;
   logic [DW-1:0] rbsum_s;
   logic          err_r;
`endif

   // State and address pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         ptr_r   <= ONE_PTR;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
      end
   end

   // Next-state, pointer advance and handshake decode.
   always_comb begin
      state_s  = state_r;
      ptr_s    = ptr_r;
      clr_s    = 1'b0;
      accept_s = 1'b0;
`ifdef REGFILE_LOADER_VERIFY_EN
      rb_en_s       = 1'b0;
      verify_last_s = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = LOAD;
               ptr_s   = ONE_PTR;
               clr_s   = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            if (in_valid) begin
               accept_s = 1'b1;
               if (ptr_r == LAST_PTR) begin
                  ptr_s   = ONE_PTR;
`ifdef REGFILE_LOADER_VERIFY_EN
                  state_s = VERIFY;
`else
                  state_s = DONE;
`endif
               end else begin
                  ptr_s   = ptr_r + ONE_PTR;
                  state_s = LOAD;
               end
            end else begin
               ptr_s = ptr_r;
            end
         end
`ifdef REGFILE_LOADER_VERIFY_EN
         VERIFY: begin
            rb_en_s = 1'b1;
            if (ptr_r == LAST_PTR) begin
               verify_last_s = 1'b1;
               ptr_s         = ONE_PTR;
               state_s       = DONE;
            end else begin
               ptr_s   = ptr_r + ONE_PTR;
               state_s = VERIFY;
            end
         end
`endif
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            ptr_s   = ONE_PTR;
         end
      endcase
   end

   // The write port is combinational so each beat commits on the edge that accepts it.
   assign in_ready = (state_r == LOAD) & ~rst;
   assign we3      = accept_s & ~rst;
   assign wa3      = we3 ? ptr_r : {AW{1'b0}};
   assign wd3      = we3 ? in_data : {DW{1'b0}};
   assign busy     = ((state_r == LOAD) | (state_r == VERIFY)) & ~rst;
   assign done     = (state_r == DONE) & ~rst;
   assign checksum = wsum_s;

   regfile_checksum #(.DW(DW)) u_wsum (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_s),
      .en   (accept_s),
      .data (in_data),
      .sum  (wsum_s)
   );

`ifdef REGFILE_LOADER_VERIFY_EN
   regfile_checksum #(.DW(DW)) u_rbsum (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_s),
      .en   (rb_en_s),
      .data (rd1),
      .sum  (rbsum_s)
   );

   // Mismatch flag: compared on the last readback cycle, held until the next start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (clr_s) begin
         err_r <= 1'b0;
      end else if (verify_last_s) begin
         err_r <= ((rbsum_s + rd1) != wsum_s);
      end else begin
         err_r <= err_r;
      end
   end

   assign ra1 = (state_r == VERIFY) ? ptr_r : {AW{1'b0}};
   assign err = err_r;
`else
   logic unused_rd1_s;
   assign unused_rd1_s = ^rd1;
   assign ra1          = {AW{1'b0}};
   assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_loader.sv
// Scoreboard bench for regfile_loader: stimulus queues expected writes and completions,
// a negedge monitor pops and compares them. Expectations follow REGFILE_LOADER_VERIFY_EN.
module tb_regfile_loader;

`ifdef REGFILE_LOADER_VERIFY_EN
   localparam bit VERIFY_ON = 1'b1;
`else
   localparam bit VERIFY_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        in_ready, we3, busy, done, err;
   logic [4:0]  wa3, ra1;
   logic [31:0] wd3, rd1, checksum;

   regfile_loader dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .rd1(rd1),
      .busy(busy), .done(done), .err(err), .checksum(checksum)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Regfile model; register 7 can be corrupted on readback
   logic [31:0] regs [0:31];
   bit corrupt = 1'b0;
   initial for (int i = 0; i < 32; i++) regs[i] = 32'd0;
   always @(posedge clk) if (we3) regs[wa3] <= wd3;
   assign rd1 = (corrupt && ra1 == 5'd7) ? regs[ra1] + 32'd1 : regs[ra1];

   typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
   typedef struct { logic [31:0] sum; logic err; int lat; int s; } dn_t;
   wr_t wr_q[$];
   dn_t dn_q[$];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops expected writes and completions whenever the DUT presents them
   always @(negedge clk) begin
      wr_t w;
      dn_t d;
      if (we3) begin
         if (wr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write: got wa3=%0d wd3=%h expected no write", wa3, wd3);
         end else begin
            w = wr_q.pop_front();
            chk("wa3", {27'd0, wa3}, {27'd0, w.a});
            chk("wd3", wd3, w.d);
         end
      end
      if (done) begin
         if (dn_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done: got done=1 expected 0");
         end else begin
            d = dn_q.pop_front();
            chk("checksum_at_done", checksum, d.sum);
            chk("err_at_done", {31'd0, err}, {31'd0, d.err});
            chk("latency", 32'(cyc - d.s + 1), 32'(d.lat));
         end
      end
   end

   function automatic logic [31:0] word(input int pat, input int k);
      case (pat)
         0:       return 32'(k + 1);
         1:       return 32'hFFFF_FFFF;
         default: return 32'(3 * k + 5);
      endcase
   endfunction

   task automatic run_load(input int pat, input bit gaps, input bit pulse,
                           input logic [31:0] exp_sum, input bit exp_err);
      dn_t e;
      wr_t w;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e.s = cyc;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("checksum_cleared", checksum, 32'd0);
      chk("err_cleared", {31'd0, err}, 32'd0);
      e.sum = exp_sum;
      e.err = exp_err;
      e.lat = (VERIFY_ON ? 63 : 32) + (gaps ? 31 : 0);
      dn_q.push_back(e);
      for (int k = 0; k < 31; k++) begin
         if (gaps) begin
            in_valid = 1'b0;
            if (pulse && k == 15) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         in_valid = 1'b1;
         in_data  = word(pat, k);
         w.a = 5'(k + 1);
         w.d = in_data;
         wr_q.push_back(w);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = 32'd0;
      for (int i = 0; i < 200 && dn_q.size() != 0; i++) @(posedge clk);
      #1;
      if (dn_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL done_timeout: got no done expected done within 200 cycles");
         dn_q.delete();
      end
      chk("writes_drained", 32'(wr_q.size()), 32'd0);
      wr_q.delete();
   endtask

   initial begin
      logic [31:0] sum_e;
      wr_t w;
      // Reset state, with a valid word offered to show the write port stays shut
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_we3", {31'd0, we3}, 32'd0);
      chk("rst_wa3", {27'd0, wa3}, 32'd0);
      chk("rst_wd3", wd3, 32'd0);
      chk("rst_ra1", {27'd0, ra1}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_checksum", checksum, 32'd0);
      in_valid = 1'b0;
      in_data  = 32'd0;
      rst = 1'b0;

      // Continuous stream 1..31
      run_load(0, 1'b0, 1'b0, 32'd496, 1'b0);
      // Gapped stream with a stray start during LOAD
      run_load(0, 1'b1, 1'b1, 32'd496, 1'b0);
      // Corrupted readback of register 7
      corrupt = 1'b1;
      run_load(0, 1'b0, 1'b0, 32'd496, VERIFY_ON);
      corrupt = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("err_held", {31'd0, err}, {31'd0, VERIFY_ON});
      chk("idle_not_busy", {31'd0, busy}, 32'd0);
      // All-ones words wrap the checksum; the start also clears the held err
      run_load(1, 1'b0, 1'b0, 32'hFFFF_FFE1, 1'b0);

      // Reset mid-LOAD with ptr at 10
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         in_valid = 1'b1;
         in_data  = word(2, k);
         w.a = 5'(k + 1);
         w.d = in_data;
         wr_q.push_back(w);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = word(2, 9);
      #1;
      chk("pre_rst_we3", {31'd0, we3}, 32'd1);
      chk("pre_rst_wa3", {27'd0, wa3}, 32'd10);
      rst = 1'b1;
      #1;
      chk("mid_rst_we3", {31'd0, we3}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_checksum", checksum, 32'd0);
      in_valid = 1'b0;
      in_data  = 32'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_writes_drained", 32'(wr_q.size()), 32'd0);
      wr_q.delete();

      // Fresh load after the abort must start at register 1
      sum_e = 32'd0;
      for (int k = 0; k < 31; k++) sum_e = sum_e + word(2, k);
      run_load(2, 1'b0, 1'b0, sum_e, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_loader.md
# regfile_loader

Sequential initiator that drives the register file's write port to bulk-load registers 1..31 from a valid/ready word stream at boot or after a debug halt. It then optionally reads every loaded register back through read port 1 and checks a running checksum, reporting pass/fail. It sits between the boot/debug stream source and the regfile's `we3/wa3/wd3/ra1/rd1` ports, muxed with the datapath writeback by the top level while `busy` is high.

## Interface
- `NUM_REGS`, 32, register count; register 0 is hardwired zero and is never written or checked.
- `DW`, 32, data width.
- `AW`, 5, address width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; ignored unless the state is IDLE.
- `in_valid`  in  1  stream word available.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_data`  in  DW  stream word; word k (k = 0..30) is written to register k+1.
- `we3`  out  1  regfile write enable.
- `wa3`  out  AW  regfile write address.
- `wd3`  out  DW  regfile write data.
- `ra1`  out  AW  regfile read address, used for verify.
- `rd1`  in  DW  regfile read data, combinational from `ra1`.
- `busy`  out  1  high in LOAD and VERIFY.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  verify mismatch flag; held until the next accepted `start`.
- `checksum`  out  DW  running sum of written words, modulo 2^DW.

## Operation
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE: when `start` is high, go to LOAD, set `ptr`=1, and clear `checksum`, the readback sum, and `err`.
- LOAD:
  - `in_ready`=1.
  - On each cycle where `in_valid & in_ready`:
    - `we3`=1, `wa3`=`ptr`, `wd3`=`in_data`. These outputs are combinational from the state register, `ptr`, and the stream inputs.
    - `checksum` += `in_data`.
    - `ptr`++.
  - When `in_valid` is low, `we3`=0 and `ptr` holds. Gaps in the stream are legal.
  - The beat accepted at `ptr`=NUM_REGS-1 moves the state to VERIFY, or to DONE when verify is compiled out.
- VERIFY:
  - `ptr` restarts at 1. `ra1`=`ptr`, and the readback sum += `rd1` every cycle.
  - After `ptr`=NUM_REGS-1 is summed, move to DONE.
  - `err` <= (readback sum + `rd1` at that last cycle) != `checksum`.
  - `in_ready`=0 and `we3`=0 throughout.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- Arithmetic: all sums are DW bits wide and wrap silently.
- `start` is ignored in LOAD, VERIFY and DONE.
- Reset (`rst` high, including mid-operation):
  - Immediately: state=IDLE, `ptr`=1, `checksum`=0, readback sum=0, `err`=0.
  - All outputs go to 0: `in_ready`, `we3`, `wa3`, `wd3`, `ra1`, `busy`, `done`, `err`, `checksum`.
  - `we3` drops asynchronously with `rst`.
  - Partially loaded registers keep whatever was written.

## Timing
- `start` seen at edge 0 → LOAD from cycle 1. With continuous `in_valid`, writes occur in cycles 1..31.
- Verify occupies cycles 32..62. `done` pulses in cycle 63. Total latency is 63 cycles, or 32 with verify compiled out.
- Each write commits at the rising edge that ends the accepting cycle.
- `err` is valid in the same cycle as `done` and holds afterwards.
- `busy`=1 exactly for cycles in LOAD or VERIFY.

## Configuration
- `REGFILE_LOADER_VERIFY_EN`:
  - Defined: the VERIFY state, the readback sum, and `err` logic are present.
  - Undefined: LOAD goes straight to DONE, `ra1` is tied 0, `err` is tied 0, and `checksum` still reports the write-side sum.

## Structure
- Shared package `regfile_pkg` holds:
  - `REG_AW`=5, `REG_DW`=32, `NUM_REGS`=32.
  - Enum `loader_state_t` {IDLE, LOAD, VERIFY, DONE}.
- One sub-module, `regfile_checksum` (inputs `clr`, `en`, `data`; output `sum`, DW-wide accumulator with async reset). It is instantiated once for the write sum and once for the readback sum; the second instance only exists under the macro.

## Test plan
- Reset, `start`, stream 1..31 with continuous valid, bench regfile model:
  - `we3` is high for 31 cycles, `wa3` steps 1..31, `wd3` equals the data.
  - `checksum`=496; `done` in cycle 63; `err`=0.
- Same data with `in_valid` low every other cycle:
  - No address is skipped or repeated; `done` comes 31 cycles later.
  - `err`=0.
- Bench model returns `rd1`+1 for register 7 during VERIFY → `err`=1 at `done`, still 1 after 10 idle cycles.
- `start` pulsed during LOAD is ignored. A new `start` after `done` clears `err` and rewrites from register 1.
- `rst` asserted mid-LOAD at `ptr`=10:
  - `we3` and `busy` go to 0 in the same cycle.
  - The next `start` writes the first word to register 1.
- All 31 words = 0xFFFFFFFF → `checksum`=0xFFFFFFE1 (wrap), `err`=0.
